// File: rtl/blk_mul_ctrl.sv
// Controller that sequences a GF(2) block multiplier over word-addressed A/B/C RAMs
// to form the word-cyclic product C = A*B, one (k,i) term per cycle.
module blk_mul_ctrl #(
    parameter int G_DAT_W  = 64,
    parameter int N_WORDS  = 159,
    parameter int G_ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [G_ADDR_W-1:0]   a_addr,
    output logic [G_ADDR_W-1:0]   b_addr0,
    output logic [G_ADDR_W-1:0]   b_addr1,
    input  logic [G_DAT_W-1:0]    a_rdata,
    input  logic [G_DAT_W-1:0]    b_rdata0,
    input  logic [G_DAT_W-1:0]    b_rdata1,
    output logic [G_DAT_W-1:0]    op_a,
    output logic [2*G_DAT_W-2:0]  op_b,
    input  logic [G_DAT_W-1:0]    mul_r,
    output logic                  c_we,
    output logic [G_ADDR_W-1:0]   c_addr,
    output logic [G_DAT_W-1:0]    c_wdata
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [G_ADDR_W-1:0] LAST  = G_ADDR_W'(N_WORDS - 1);
    localparam logic [G_ADDR_W:0]   NW_X  = (G_ADDR_W + 1)'(N_WORDS);
    localparam logic [G_ADDR_W:0]   NM1_X = (G_ADDR_W + 1)'(N_WORDS - 1);
    localparam logic [G_ADDR_W:0]   ONE_X = (G_ADDR_W + 1)'(1);

    state_t                state_q, state_d;
    logic [G_ADDR_W-1:0]   k_q, k_d, i_q, i_d;
    logic                  drain_q, drain_d;
    logic                  v1_q, v2_q;
    logic [G_ADDR_W-1:0]   i1_q, k1_q, i2_q, k2_q;
    logic [G_DAT_W-1:0]    acc_q;
    logic                  issue;
    logic                  flush;
    logic [G_ADDR_W:0]     j_x, jm1_x;
    logic [2:0]            unused_bits;

    // Index arithmetic is one bit wider so k+N_WORDS cannot overflow before the subtract.
    always_comb begin
        if (k_q >= i_q) begin
            j_x = {1'b0, k_q} - {1'b0, i_q};
        end else begin
            j_x = {1'b0, k_q} + NW_X - {1'b0, i_q};
        end
        jm1_x = (j_x == '0) ? NM1_X : (j_x - ONE_X);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        drain_d = drain_q;
        issue   = 1'b0;
        flush   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    k_d     = '0;
                    i_d     = '0;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                issue = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                    k_d     = '0;
                    i_d     = '0;
                end else if (i_q == LAST) begin
                    i_d = '0;
                    if (k_q == LAST) begin
                        state_d = S_DRAIN;
                        k_d     = '0;
                        drain_d = 1'b0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                    flush   = 1'b1;
                end else if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            i1_q    <= '0;
            k1_q    <= '0;
            i2_q    <= '0;
            k2_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            drain_q <= drain_d;
            // Stage 1 tracks the RAM read, stage 2 the multiplier register.
            v1_q    <= issue && !flush;
            v2_q    <= v1_q && !flush;
            i1_q    <= i_q;
            k1_q    <= k_q;
            i2_q    <= i1_q;
            k2_q    <= k1_q;
            if (v2_q) begin
                acc_q <= (i2_q == '0) ? mul_r : (acc_q ^ mul_r);
            end
        end
    end

    assign a_addr  = issue ? i_q : '0;
    assign b_addr0 = issue ? j_x[G_ADDR_W-1:0] : '0;
    assign b_addr1 = issue ? jm1_x[G_ADDR_W-1:0] : '0;

    assign op_a = a_rdata;
    assign op_b = {b_rdata0[G_DAT_W-2:0], b_rdata1};

    assign c_we    = v2_q && (i2_q == LAST);
    assign c_addr  = c_we ? k2_q : '0;
    assign c_wdata = (N_WORDS == 1) ? mul_r : (acc_q ^ mul_r);

    assign unused_bits = {b_rdata0[G_DAT_W-1], j_x[G_ADDR_W], jm1_x[G_ADDR_W]};
endmodule

// File: doc/blk_mul_ctrl.md
Name: blk_mul_ctrl

Overview:
- Sequences the 64x64 GF(2) block multiplier (blk_mul: op_a G bits, op_b 2G-1 bits, registered mul_r one cycle after operands) to compute a word-cyclic polynomial product C = A*B over N_WORDS-word operand RAMs.
- Generates the A and B read addresses and forms op_b from two B words.
- Accumulates partial products and writes each finished result word to the C RAM.
- Sits between the key-generation top-level FSM and the multiplier/RAM datapath. Reduction mod x^r-1 beyond word granularity is done downstream.

Parameters:
- G_DAT_W, 64, word width; must match the multiplier.
- N_WORDS, 159, words per operand (ceil(10163/64)).
- G_ADDR_W, 8, RAM address width; 2^G_ADDR_W >= N_WORDS.

Ports:
- clk  in  1  clock
- rst_b  in  1  synchronous reset, active-high (asserted = 1) despite the name
- start  in  1  one-cycle start request; honoured only in IDLE
- abort  in  1  cancels a running job
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the last C word has been written
- a_addr  out  G_ADDR_W  A RAM read address
- b_addr0  out  G_ADDR_W  B RAM port 0 read address (word j)
- b_addr1  out  G_ADDR_W  B RAM port 1 read address (word j-1 mod N_WORDS)
- a_rdata  in  G_DAT_W  A RAM data; 1-cycle read latency
- b_rdata0  in  G_DAT_W  B port 0 data; 1-cycle read latency
- b_rdata1  in  G_DAT_W  B port 1 data; 1-cycle read latency
- op_a  out  G_DAT_W  to multiplier; = a_rdata
- op_b  out  2*G_DAT_W-1  to multiplier; = {b_rdata0[G_DAT_W-2:0], b_rdata1}
- mul_r  in  G_DAT_W  multiplier result
- c_we  out  1  C RAM write enable
- c_addr  out  G_ADDR_W  C RAM write address
- c_wdata  out  G_DAT_W  C RAM write data

Behaviour:
- Math: C[k] = XOR over i=0..N_WORDS-1 of blkmul(A[i], {B[j][G-2:0], B[j-1]}), with j=(k-i) mod N_WORDS and j-1 taken mod N_WORDS.
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> RUN with k=0, i=0.
- RUN: issues one (k,i) address set per cycle, i innermost. Wraps i -> 0 and increments k with no bubbles. After issuing (N_WORDS-1, N_WORDS-1) -> DRAIN.
- DRAIN: 2 cycles, flushing RAM and multiplier latency, then -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Pipeline: addresses issued cycle n; operands valid at multiplier cycle n+1; mul_r valid cycle n+2. Controller carries i and k in 2-stage valid/index shift registers.
- Accumulator, at mul_r stage with valid=1:
  - i==0: acc <= mul_r.
  - else: acc <= acc ^ mul_r.
- Write: at mul_r stage with valid=1 and i==N_WORDS-1, in the same cycle:
  - c_we=1, c_addr=k.
  - c_wdata = acc ^ mul_r, or mul_r alone if N_WORDS==1.
- Timing, with start sampled at cycle 0:
  - first issue at cycle 1;
  - C[k] written at cycle (k+1)*N_WORDS+2;
  - done at cycle N_WORDS^2+3;
  - busy=1 in cycles 1..N_WORDS^2+2, 0 in IDLE and DONE.
- Address wrap: j and j-1 computed by conditional add of N_WORDS, never by modulo. b_addr1 = N_WORDS-1 when j=0.
- start while not IDLE: ignored.
- start and abort in the same IDLE cycle: start wins.
- abort in RUN/DRAIN: next cycle IDLE; pipeline valids cleared; no further c_we; done not pulsed.
- Reset (rst_b=1), including mid-operation: state IDLE; counters, valids and acc cleared; busy=0, done=0, c_we=0; all addresses 0. c_wdata is don't-care while c_we=0.
- op_a and op_b are combinational pass-throughs. Multiplier reset is driven separately by the top level.

Test Plan:
- N_WORDS=2, G_DAT_W=64, A={0x8000_0000_0000_0000, 0}, B={0x1111..11, 0x2222..22}, start at cycle 0 -> C[0]=0x2222..22 written at cycle 4, C[1]=0x1111..11 at cycle 6, done at cycle 7, busy high cycles 1..6.
- N_WORDS=4, A all zero, random B -> four writes, all c_wdata=0, c_addr 0,1,2,3 at cycles 6,10,14,18; done at cycle 19.
- N_WORDS=4, random A/B vs a software golden model of the math above -> all four C words bit-exact. Check the b_addr1 wrap: j=0 gives b_addr1=3.
- Start pulsed again at cycle 5 of a running job -> ignored; exactly N_WORDS writes and one done pulse.
- Abort at cycle 7 with N_WORDS=4 -> busy=0 from cycle 8; only C[0] written (cycle 6); no done; a following start runs a full, correct job.
- rst_b=1 at cycle 9 mid-run -> cycle 10 all outputs at reset values, no write after cycle 9; a subsequent start produces correct results.
